// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction fields and ALU flags in, datapath controls out.
// The control unit takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 3
);
  logic [6:0]           opcode;
  logic [2:0]           func3;
  logic                 func7;
  logic                 Zero_Flag;
  logic                 Sign_Flag;
  logic                 MemReady;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [1:0]           ImmSrc;
  logic                 RegWrite;
  logic                 InstrDone;
  logic                 Illegal;
  logic [3:0]           State;

  modport master (
    input  opcode, func3, func7, Zero_Flag, Sign_Flag, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, InstrDone, Illegal, State
  );

  modport slave (
    output opcode, func3, func7, Zero_Flag, Sign_Flag, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, InstrDone, Illegal, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-ready handshake, Moore-style datapath controls and illegal-opcode flag.
module multicycle_control_unit #(
  parameter int ALUCTRL_W  = 3,
  parameter bit BRANCH_EXT = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  multicycle_control_unit_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] alu_dec;
  logic [2:0] alu_op;
  logic       taken;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // sub only for R-type (opcode[5]) with func7 set; I-type ignores func7
  always_comb begin
    alu_dec = ALU_ADD;
    case (bus.func3)
      3'b000:  alu_dec = (bus.opcode[5] && bus.func7) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (BRANCH_EXT) begin
      case (bus.func3)
        3'b000:  taken = bus.Zero_Flag;
        3'b001:  taken = !bus.Zero_Flag;
        3'b100:  taken = bus.Sign_Flag;
        3'b101:  taken = !bus.Sign_Flag;
        default: taken = 1'b0;
      endcase
    end else begin
      taken = (bus.func3 == 3'b000) && bus.Zero_Flag;
    end
  end

  always_comb begin
    state_nxt     = state;
    alu_op        = ALU_ADD;
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.RegWrite  = 1'b0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
        state_nxt     = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BR:        state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            state_nxt   = S_FETCH;
            bus.Illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_nxt   = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_nxt  = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.InstrDone = bus.MemReady;
        state_nxt     = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = alu_dec;
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op      = alu_dec;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        state_nxt     = S_FETCH;
      end
      // PC takes the jump target from ALUOut; ALU computes OldPC+4 for the link
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_nxt   = S_ALUWB;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 2'b10;
        alu_op        = ALU_SUB;
        bus.PCWrite   = taken;
        bus.InstrDone = 1'b1;
        state_nxt     = S_FETCH;
      end
      // unused codes behave like FETCH for one cycle, then recover
      default: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
        state_nxt     = S_FETCH;
      end
    endcase
  end

  always_comb begin
    case (bus.opcode)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BR:   bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  assign bus.ALUControl = ALUCTRL_W'(alu_op);
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level reference model expanded into
// per-cycle expected outputs, checked on both branch-set variants, plus directed literals.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXECR = 6, EXECI = 7, ALUWB = 8, JAL = 9, BRANCH = 10;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw, dn, il;
  } rec_t;

  typedef struct {
    string nm;
    int    act;
    int    ex;
  } chk_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  multicycle_control_unit_if #(.ALUCTRL_W(3)) bus1 ();
  multicycle_control_unit_if #(.ALUCTRL_W(3)) bus0 ();

  multicycle_control_unit #(.ALUCTRL_W(3), .BRANCH_EXT(1'b1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  multicycle_control_unit #(.ALUCTRL_W(3), .BRANCH_EXT(1'b0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

  assign bus0.opcode    = bus1.opcode;
  assign bus0.func3     = bus1.func3;
  assign bus0.func7     = bus1.func7;
  assign bus0.Zero_Flag = bus1.Zero_Flag;
  assign bus0.Sign_Flag = bus1.Sign_Flag;
  assign bus0.MemReady  = bus1.MemReady;

  rec_t       exp1_q[$], exp0_q[$];
  chk_t       chk_q[$];
  logic [3:0] obs_st[$];
  logic [2:0] obs_alu[$];
  logic       obs_pcw1[$], obs_pcw0[$];
  int         total = 0;
  int         bad = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7, cur_z, cur_s;

  function automatic logic known_op(logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR || op == OP_JAL;
  endfunction

  // Expected outputs for one cycle, straight from the per-state output table
  function automatic rec_t exp_rec(int st, logic mr, bit bext);
    rec_t r;
    logic t;
    r = '0;
    r.st  = 4'(st);
    r.imm = (cur_op == OP_SW) ? 2'b01 : (cur_op == OP_BR) ? 2'b10 : (cur_op == OP_JAL) ? 2'b11 : 2'b00;
    case (st)
      FETCH:    begin r.b = 2; r.rs = 2; r.pcw = mr; r.irw = mr; end
      DECODE:   begin r.a = 1; r.b = 1; r.il = !known_op(cur_op); end
      MEMADR:   begin r.a = 2; r.b = 1; end
      MEMREAD:  r.adr = 1;
      MEMWB:    begin r.rs = 1; r.rw = 1; r.dn = 1; end
      MEMWRITE: begin r.adr = 1; r.mw = 1; r.dn = mr; end
      EXECR, EXECI: begin
        r.a = 2;
        r.b = (st == EXECI) ? 2'd1 : 2'd0;
        case (cur_f3)
          3'd0:    r.alu = (cur_op[5] && cur_f7) ? 3'b001 : 3'b000;
          3'd2:    r.alu = 3'b101;
          3'd6:    r.alu = 3'b011;
          3'd7:    r.alu = 3'b010;
          default: r.alu = 3'b000;
        endcase
      end
      ALUWB:    begin r.rw = 1; r.dn = 1; end
      JAL:      begin r.a = 1; r.b = 2; r.pcw = 1; end
      BRANCH: begin
        if (bext) t = (cur_f3 == 0) ? cur_z : (cur_f3 == 1) ? !cur_z :
                      (cur_f3 == 4) ? cur_s : (cur_f3 == 5) ? !cur_s : 1'b0;
        else      t = (cur_f3 == 0) && cur_z;
        r.a = 2; r.alu = 3'b001; r.pcw = t; r.dn = 1;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic void lit(string nm, int act, int ex);
    chk_t c;
    c.nm = nm; c.act = act; c.ex = ex;
    chk_q.push_back(c);
  endfunction

  always @(negedge CLK) begin
    rec_t e1, e0, a1, a0;
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act != c.ex) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", c.nm, c.act, c.ex);
      end
    end
    if (exp1_q.size() > 0) begin
      e1 = exp1_q.pop_front();
      e0 = exp0_q.pop_front();
      a1 = '{st:bus1.State, pcw:bus1.PCWrite, adr:bus1.AdrSrc, mw:bus1.MemWrite, irw:bus1.IRWrite,
             rs:bus1.ResultSrc, a:bus1.ALUSrcA, b:bus1.ALUSrcB, alu:bus1.ALUControl, imm:bus1.ImmSrc,
             rw:bus1.RegWrite, dn:bus1.InstrDone, il:bus1.Illegal};
      a0 = '{st:bus0.State, pcw:bus0.PCWrite, adr:bus0.AdrSrc, mw:bus0.MemWrite, irw:bus0.IRWrite,
             rs:bus0.ResultSrc, a:bus0.ALUSrcA, b:bus0.ALUSrcB, alu:bus0.ALUControl, imm:bus0.ImmSrc,
             rw:bus0.RegWrite, dn:bus0.InstrDone, il:bus0.Illegal};
      total++;
      if (a1 !== e1) begin
        bad++;
        $display("FAIL cycle_ext1 t=%0t op=%b f3=%0d: got %h expected %h", $time, cur_op, cur_f3, a1, e1);
      end
      total++;
      if (a0 !== e0) begin
        bad++;
        $display("FAIL cycle_ext0 t=%0t op=%b f3=%0d: got %h expected %h", $time, cur_op, cur_f3, a0, e0);
      end
      obs_st.push_back(bus1.State);
      obs_alu.push_back(bus1.ALUControl);
      obs_pcw1.push_back(bus1.PCWrite);
      obs_pcw0.push_back(bus0.PCWrite);
    end
  end

  task automatic step(input int st, input logic mr);
    bus1.MemReady = mr;
    exp1_q.push_back(exp_rec(st, mr, 1'b1));
    exp0_q.push_back(exp_rec(st, mr, 1'b0));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic s, input int wf, input int wm);
    int ms;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_s = s;
    bus1.opcode = op; bus1.func3 = f3; bus1.func7 = f7;
    bus1.Zero_Flag = z; bus1.Sign_Flag = s;
    for (int i = 0; i < wf; i++) step(FETCH, 1'b0);
    step(FETCH, 1'b1);
    step(DECODE, 1'($urandom_range(0, 1)));
    if (op == OP_LW || op == OP_SW) begin
      ms = (op == OP_LW) ? MEMREAD : MEMWRITE;
      step(MEMADR, 1'($urandom_range(0, 1)));
      for (int i = 0; i < wm; i++) step(ms, 1'b0);
      step(ms, 1'b1);
      if (op == OP_LW) step(MEMWB, 1'($urandom_range(0, 1)));
    end else if (op == OP_R || op == OP_I || op == OP_JAL) begin
      step((op == OP_R) ? EXECR : (op == OP_I) ? EXECI : JAL, 1'($urandom_range(0, 1)));
      step(ALUWB, 1'($urandom_range(0, 1)));
    end else if (op == OP_BR) begin
      step(BRANCH, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check_seq(input string nm, input int base, input int len, input int s[8]);
    lit({nm, "_len"}, obs_st.size() - base, len);
    for (int i = 0; i < len && base + i < obs_st.size(); i++)
      lit({nm, "_state"}, int'(obs_st[base + i]), s[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b;
    int s[8];
    logic [6:0] op;
    RST = 1'b1;
    bus1.opcode = 7'd0; bus1.func3 = 3'd0; bus1.func7 = 1'b0;
    bus1.Zero_Flag = 1'b0; bus1.Sign_Flag = 1'b0; bus1.MemReady = 1'b0;
    cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 1'b0; cur_z = 1'b0; cur_s = 1'b0;
    #2;
    lit("rst_state", int'(bus1.State), 0);
    lit("rst_pcwrite", int'(bus1.PCWrite), 0);
    lit("rst_resultsrc", int'(bus1.ResultSrc), 2);
    lit("rst_alusrcb", int'(bus1.ALUSrcB), 2);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    b = obs_st.size(); do_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    s = '{0, 1, 6, 8, 0, 0, 0, 0}; check_seq("add", b, 4, s);
    lit("add_alu", int'(obs_alu[b + 2]), 0);

    b = obs_st.size(); do_instr(OP_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    lit("sub_alu", int'(obs_alu[b + 2]), 1);
    b = obs_st.size(); do_instr(OP_I, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    lit("addi_f7_alu", int'(obs_alu[b + 2]), 0);

    b = obs_st.size(); do_instr(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2);
    s = '{0, 1, 2, 3, 3, 3, 4, 0}; check_seq("lw_wait", b, 7, s);

    b = obs_st.size(); do_instr(OP_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
    lit("bne_pcw_ext1", int'(obs_pcw1[b + 2]), 1);
    lit("bne_pcw_ext0", int'(obs_pcw0[b + 2]), 0);
    b = obs_st.size(); do_instr(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);
    lit("beq_pcw_ext1", int'(obs_pcw1[b + 2]), 1);
    lit("beq_pcw_ext0", int'(obs_pcw0[b + 2]), 1);

    b = obs_st.size(); do_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    s = '{0, 1, 0, 0, 0, 0, 0, 0}; check_seq("illegal", b, 2, s);
    b = obs_st.size(); do_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);
    s = '{0, 0, 1, 9, 8, 0, 0, 0}; check_seq("jal", b, 5, s);
    lit("jal_pcw", int'(obs_pcw1[b + 3]), 1);

    // reset pulse in the middle of a store that is waiting on memory
    cur_op = OP_SW;
    bus1.opcode = OP_SW; bus1.func3 = 3'd2; bus1.MemReady = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    bus1.MemReady = 1'b0;
    @(posedge CLK); #1;
    lit("sw_state", int'(bus1.State), 5);
    lit("sw_memwrite", int'(bus1.MemWrite), 1);
    lit("sw_done_wait", int'(bus1.InstrDone), 0);
    #2 RST = 1'b1;
    #1;
    lit("rst_mid_state", int'(bus1.State), 0);
    lit("rst_mid_memwrite", int'(bus1.MemWrite), 0);
    lit("rst_mid_pcw_lo", int'(bus1.PCWrite), 0);
    bus1.MemReady = 1'b1;
    #1;
    lit("rst_mid_pcw_hi", int'(bus1.PCWrite), 1);
    lit("rst_mid_irw_hi", int'(bus1.IRWrite), 1);
    lit("rst_mid_immsrc", int'(bus1.ImmSrc), 1);
    lit("rst_mid_alu", int'(bus1.ALUControl), 0);
    lit("rst_mid_regwrite", int'(bus1.RegWrite), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    lit("post_rst_state", int'(bus1.State), 0);
    lit("post_rst_pcw", int'(bus1.PCWrite), 1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_BR;
        5: op = OP_JAL;
        default: begin
          op = 7'($urandom_range(0, 127));
          if (known_op(op)) op = 7'b1111111;
        end
      endcase
      do_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(negedge CLK); @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- **Function:** Parametrised multi-cycle control FSM for the RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states.
- **Decode:** Uses the same opcode/func3/func7 decode and flag-based branch resolution as the single-cycle control path.
- **Extensions:** Adds a memory-ready handshake, the JAL and I-type ALU paths, an optional extended branch set (bne/blt/bge) and an illegal-opcode indication.
- **Placement:** Sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface
Parameters:
- ALUCTRL_W, 3: ALUControl width, ≥3; bits above [2] driven 0.
- BRANCH_EXT, 1: 1 = beq/bne/blt/bge supported; 0 = beq only, other func3 never taken.

Ports:
- CLK  in  1  clock; single clock domain, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- opcode  in  7  instruction opcode from instruction register.
- func3  in  3  instruction[14:12].
- func7  in  1  instruction[30].
- Zero_Flag  in  1  ALU result zero.
- Sign_Flag  in  1  ALU result negative.
- MemReady  in  1  memory completes access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction/OldPC register enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU operand B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ALUControl  out  ALUCTRL_W  ALU operation.
- ImmSrc  out  2  immediate format: I = 00, S = 01, B = 10, J = 11.
- RegWrite  out  1  register file write enable.
- InstrDone  out  1  high in the final cycle of each instruction.
- Illegal  out  1  unknown opcode seen in DECODE.
- State  out  4  current state, for debug.

## Operation
**Opcode classes:**
- lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111.

**State encoding:**
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, JAL 9, BRANCH 10.
- Codes 11–15 transition to FETCH next cycle with all outputs at their FETCH values.

**Per-state outputs and transitions** (Moore outputs; any signal not listed is 0):
- **FETCH:** AdrSrc=0, A=00, B=10, ALUOp add, ResultSrc=10. IRWrite = PCWrite = MemReady. Go to DECODE if MemReady, else stay.
- **DECODE:** A=01, B=01, add (branch target into ALUOut). Next state:
  - lw/sw → MEMADR
  - R → EXECR
  - I-ALU → EXECI
  - branch → BRANCH
  - jal → JAL
  - otherwise → FETCH with Illegal=1 for this cycle.
- **MEMADR:** A=10, B=01, add. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
- **MEMREAD:** AdrSrc=1. Go to MEMWB when MemReady.
- **MEMWB:** ResultSrc=01, RegWrite=1, InstrDone=1. Go to FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=1, held until MemReady. InstrDone = MemReady. Go to FETCH when MemReady.
- **EXECR / EXECI:** A=10; B=00 (EXECR) or 01 (EXECI); ALU decode from func3. Go to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, InstrDone=1. Go to FETCH.
- **JAL:** A=01, B=10, ResultSrc=00, PCWrite=1 (PC ← ALUOut target). Go to ALUWB, which writes the link value OldPC+4.
- **BRANCH:** A=10, B=00, sub, ResultSrc=00, InstrDone=1. PCWrite = taken. Go to FETCH.
  - Branch condition by func3: 000 Zero_Flag; 001 !Zero_Flag; 100 Sign_Flag; 101 !Sign_Flag.

**ALU decode** (applies in EXECR/EXECI):
- func3 000 → sub (001) if opcode[5] & func7 (R-type only), else add (000).
- func3 010 → slt (101).
- func3 110 → or (011).
- func3 111 → and (010).
- Any other func3 → add.

**ImmSrc:**
- Combinational from opcode in every state: sw → 01, branch → 10, jal → 11, else 00.

## Timing
**Reset:**
- RST asserted → State=FETCH immediately (asynchronous), including mid-instruction. Any pending MemWrite drops at once.
- Output values during reset:
  - Combinational from MemReady: PCWrite, IRWrite.
  - From opcode: ImmSrc.
  - From func3: ALUControl = 000 (FETCH uses add).
  - Zero: MemWrite, RegWrite, InstrDone, Illegal, AdrSrc.
  - Fixed values: ResultSrc=10, ALUSrcA=00, ALUSrcB=10.

**Cycles per instruction** with MemReady held 1:
- lw 5, sw 4, R/I 4, jal 4, branch 3, illegal 2.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- All outputs are stable for the whole wait.

**Input sampling and other rules:**
- Zero_Flag/Sign_Flag are sampled only in BRANCH.
- MemReady is ignored in all other states.
- opcode/func fields must stay stable from DECODE until the instruction ends; IRWrite is only high in FETCH.
- InstrDone is high for exactly one cycle per completed instruction and never for illegal ones.

## Test plan
- RST pulse mid-MEMWRITE (MemWrite=1) → State=0, MemWrite=0 the same cycle; after release, FETCH with PCWrite=IRWrite=1 once MemReady=1.
- add x (opcode 0110011, func3 000, func7 0), MemReady=1 → states 0,1,6,8; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
- sub, then addi with func7 bit=1 → ALUControl 001 in EXECR, but 000 in EXECI.
- lw with MemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4; InstrDone only in MEMWB; total 7 cycles.
- bne with Zero_Flag=0 → PCWrite=1 in BRANCH. Same instruction with BRANCH_EXT=0 → PCWrite=0. beq with Zero_Flag=1 → PCWrite=1.
- opcode 1111111 → states 0,1,0; Illegal=1 in DECODE, InstrDone never asserted. jal → states 0,1,9,8 with PCWrite in JAL and RegWrite in ALUWB.
